// File: rtl/plab5_mcore_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// plab5_mcore_mem_req_arbiter
//
// Merges one core's icache and dcache memory request streams into a single
// request path toward the memory-to-network adapter. Grants are round-robin
// between the two ports, and the winner is registered in a one-entry output
// buffer. When the next grant would change security domain, the arbiter first
// drains the buffer and then idles for p_switch_gap cycles. This makes the
// timing of a domain switch independent of the data being sent.
//
// Ports
//   clk_i                 clock; all state updates on the rising edge
//   reset_i               asynchronous, active-high reset
//   inst_req_val_i/rdy_o  icache request handshake
//   inst_req_msg_i        icache memory request message
//   inst_domain_i         security domain of the icache request
//   data_req_val_i/rdy_o  dcache request handshake
//   data_req_msg_i        dcache memory request message
//   data_domain_i         security domain of the dcache request
//   out_val_o/out_rdy_i   buffered request handshake toward the adapter
//   out_msg_o             buffered request message
//   out_mode_o            0 = buffered request came from inst, 1 = from data
//   out_domain_o          domain of the buffered request
// -----------------------------------------------------------------------------
module plab5_mcore_mem_req_arbiter #(
    parameter int unsigned p_mem_opaque_nbits = 8,
    parameter int unsigned p_mem_addr_nbits   = 32,
    parameter int unsigned p_mem_data_nbits   = 32,
    parameter int unsigned p_switch_gap       = 2,
    // type(3) + opaque + addr + len + data
    localparam int unsigned c_msg_nbits = 3 + p_mem_opaque_nbits + p_mem_addr_nbits
                                          + $clog2(p_mem_data_nbits / 8) + p_mem_data_nbits
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic                   inst_req_val_i,
    output logic                   inst_req_rdy_o,
    input  logic [c_msg_nbits-1:0] inst_req_msg_i,
    input  logic                   inst_domain_i,

    input  logic                   data_req_val_i,
    output logic                   data_req_rdy_o,
    input  logic [c_msg_nbits-1:0] data_req_msg_i,
    input  logic                   data_domain_i,

    output logic                   out_val_o,
    input  logic                   out_rdy_i,
    output logic [c_msg_nbits-1:0] out_msg_o,
    output logic                   out_mode_o,
    output logic                   out_domain_o
);

    localparam int unsigned GapW = (p_switch_gap > 0) ? $clog2(p_switch_gap + 1) : 1;
    localparam logic [GapW-1:0] GapInit = GapW'(p_switch_gap);
    localparam logic [GapW-1:0] GapOne  = GapW'(1);

    typedef enum logic [1:0] {StRun, StDrain, StGap} state_e;

    state_e                 state_q, state_d;
    logic                   full_q, full_d;
    logic [c_msg_nbits-1:0] msg_q, msg_d;
    logic                   mode_q, mode_d;
    logic                   dom_q, dom_d;
    logic                   last_q, last_d;
    logic                   cur_dom_q, cur_dom_d;
    logic [GapW-1:0]        gap_q, gap_d;
    logic                   lock_q, lock_d;
    // Set for the RUN cycle(s) after GAP: the locked port is owed the next grant.
    logic                   lock_act_q, lock_act_d;

    logic deq, space;
    logic cand_vld, cand, cand_dom;
    logic lock_vld, lock_dom;
    logic grant, grant_port, grant_dom;

    always_comb begin
        deq      = full_q && out_rdy_i;
        space    = !full_q || out_rdy_i;

        // With a tie, the port that did not win last time is the candidate.
        cand_vld = inst_req_val_i || data_req_val_i;
        cand     = (inst_req_val_i && data_req_val_i) ? ~last_q : data_req_val_i;
        cand_dom = cand ? data_domain_i : inst_domain_i;

        lock_vld = lock_q ? data_req_val_i : inst_req_val_i;
        lock_dom = lock_q ? data_domain_i  : inst_domain_i;

        state_d    = state_q;
        gap_d      = gap_q;
        lock_d     = lock_q;
        lock_act_d = lock_act_q;
        cur_dom_d  = cur_dom_q;
        last_d     = last_q;
        grant      = 1'b0;
        grant_port = cand;

        unique case (state_q)
            StRun: begin
                if (lock_act_q) begin
                    // Round-robin and domain check are bypassed for the held port.
                    if (lock_vld && space) begin
                        grant      = 1'b1;
                        grant_port = lock_q;
                        lock_act_d = 1'b0;
                    end
                end else if (cand_vld && space) begin
                    if (p_switch_gap == 0 || cand_dom == cur_dom_q) begin
                        grant = 1'b1;
                    end else begin
                        lock_d  = cand;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!full_q || deq) begin
                    gap_d     = GapInit;
                    cur_dom_d = lock_dom;
                    state_d   = StGap;
                end
            end
            StGap: begin
                gap_d = gap_q - GapOne;
                if (gap_q == GapOne) begin
                    state_d    = StRun;
                    lock_act_d = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase

        grant_dom = grant_port ? data_domain_i : inst_domain_i;
        if (grant) begin
            last_d    = grant_port;
            cur_dom_d = grant_dom;
        end

        full_d = full_q;
        msg_d  = msg_q;
        mode_d = mode_q;
        dom_d  = dom_q;
        if (grant) begin
            // Covers both the empty case and a same-cycle dequeue (overwrite).
            full_d = 1'b1;
            msg_d  = grant_port ? data_req_msg_i : inst_req_msg_i;
            mode_d = grant_port;
            dom_d  = grant_dom;
        end else if (deq) begin
            full_d = 1'b0;
        end

        inst_req_rdy_o = grant && !grant_port && !reset_i;
        data_req_rdy_o = grant &&  grant_port && !reset_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StRun;
            full_q     <= 1'b0;
            msg_q      <= '0;
            mode_q     <= 1'b0;
            dom_q      <= 1'b0;
            last_q     <= 1'b1;
            cur_dom_q  <= 1'b0;
            gap_q      <= '0;
            lock_q     <= 1'b0;
            lock_act_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            msg_q      <= msg_d;
            mode_q     <= mode_d;
            dom_q      <= dom_d;
            last_q     <= last_d;
            cur_dom_q  <= cur_dom_d;
            gap_q      <= gap_d;
            lock_q     <= lock_d;
            lock_act_q <= lock_act_d;
        end
    end

    assign out_val_o    = full_q;
    assign out_msg_o    = msg_q;
    assign out_mode_o   = mode_q;
    assign out_domain_o = dom_q;

endmodule

// File: tb/tb_plab5_mcore_mem_req_arbiter.sv
module tb_plab5_mcore_mem_req_arbiter;

    localparam int unsigned MsgW = 3 + 8 + 32 + 2 + 32;

    typedef struct packed {
        logic            mode;
        logic            dom;
        logic [MsgW-1:0] msg;
    } entry_t;

    logic            clk, reset;
    logic            inst_val, inst_dom, data_val, data_dom, out_rdy;
    logic [MsgW-1:0] inst_msg, data_msg;

    // Gap-2 instance
    logic            irdy2, drdy2, oval2, omode2, odom2;
    logic [MsgW-1:0] omsg2;
    // Gap-0 instance
    logic            irdy0, drdy0, oval0, omode0, odom0;
    logic [MsgW-1:0] omsg0;

    logic            sel0;
    logic            o_irdy, o_drdy, o_val, o_mode, o_dom;
    logic [MsgW-1:0] o_msg;

    int     errors = 0;
    int     checks = 0;
    entry_t sb[$];

    plab5_mcore_mem_req_arbiter #(.p_switch_gap(2)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .inst_req_val_i (inst_val),
        .inst_req_rdy_o (irdy2),
        .inst_req_msg_i (inst_msg),
        .inst_domain_i  (inst_dom),
        .data_req_val_i (data_val),
        .data_req_rdy_o (drdy2),
        .data_req_msg_i (data_msg),
        .data_domain_i  (data_dom),
        .out_val_o      (oval2),
        .out_rdy_i      (out_rdy),
        .out_msg_o      (omsg2),
        .out_mode_o     (omode2),
        .out_domain_o   (odom2)
    );

    plab5_mcore_mem_req_arbiter #(.p_switch_gap(0)) dut0 (
        .clk_i          (clk),
        .reset_i        (reset),
        .inst_req_val_i (inst_val),
        .inst_req_rdy_o (irdy0),
        .inst_req_msg_i (inst_msg),
        .inst_domain_i  (inst_dom),
        .data_req_val_i (data_val),
        .data_req_rdy_o (drdy0),
        .data_req_msg_i (data_msg),
        .data_domain_i  (data_dom),
        .out_val_o      (oval0),
        .out_rdy_i      (out_rdy),
        .out_msg_o      (omsg0),
        .out_mode_o     (omode0),
        .out_domain_o   (odom0)
    );

    assign o_irdy = sel0 ? irdy0  : irdy2;
    assign o_drdy = sel0 ? drdy0  : drdy2;
    assign o_val  = sel0 ? oval0  : oval2;
    assign o_mode = sel0 ? omode0 : omode2;
    assign o_dom  = sel0 ? odom0  : odom2;
    assign o_msg  = sel0 ? omsg0  : omsg2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [MsgW-1:0] rand_msg();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[MsgW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [MsgW-1:0] obs, input logic [MsgW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the rising edge, check at the falling edge,
    // score any dequeue against the queue, and record expected grants.
    task automatic step(input logic iv, input logic id, input logic dv, input logic dd,
                        input logic ordy, input logic exp_i, input logic exp_d,
                        input logic exp_v, input string tag);
        entry_t e;
        inst_val = iv;
        inst_dom = id;
        data_val = dv;
        data_dom = dd;
        out_rdy  = ordy;
        inst_msg = rand_msg();
        data_msg = rand_msg();
        @(negedge clk);
        chk({tag, "_irdy"}, MsgW'(o_irdy), MsgW'(exp_i));
        chk({tag, "_drdy"}, MsgW'(o_drdy), MsgW'(exp_d));
        chk({tag, "_oval"}, MsgW'(o_val), MsgW'(exp_v));
        if (o_val && ordy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_sb: observed=unexpected dequeue expected=empty buffer", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, "_mode"}, MsgW'(o_mode), MsgW'(e.mode));
                chk({tag, "_dom"},  MsgW'(o_dom),  MsgW'(e.dom));
                chk({tag, "_msg"},  o_msg,         e.msg);
            end
        end
        if (exp_i) sb.push_back('{mode: 1'b0, dom: id, msg: inst_msg});
        if (exp_d) sb.push_back('{mode: 1'b1, dom: dd, msg: data_msg});
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel0     = 1'b0;
        reset    = 1'b1;
        inst_val = 1'b1;
        data_val = 1'b1;
        inst_dom = 1'b0;
        data_dom = 1'b0;
        inst_msg = rand_msg();
        data_msg = rand_msg();
        out_rdy  = 1'b1;

        // Reset state, with requesters valid
        repeat (2) @(negedge clk);
        chk("rst_oval", MsgW'(o_val), '0);
        chk("rst_irdy", MsgW'(o_irdy), '0);
        chk("rst_drdy", MsgW'(o_drdy), '0);
        chk("rst_mode", MsgW'(o_mode), '0);
        chk("rst_dom",  MsgW'(o_dom),  '0);
        chk("rst_msg",  o_msg,         '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lone inst after reset: granted at once, visible next cycle
        step(1, 0, 0, 0, 1, 1, 0, 0, "lone0");
        step(0, 0, 0, 0, 1, 0, 0, 1, "lone1");
        step(0, 0, 0, 0, 1, 0, 0, 0, "lone2");

        // Round-robin tie: last grant was inst, so data leads
        step(1, 0, 1, 0, 1, 0, 1, 0, "rr0");
        step(1, 0, 1, 0, 1, 1, 0, 1, "rr1");
        step(1, 0, 1, 0, 1, 0, 1, 1, "rr2");
        step(1, 0, 1, 0, 1, 1, 0, 1, "rr3");
        step(0, 0, 0, 0, 1, 0, 0, 1, "rr4");
        step(0, 0, 0, 0, 1, 0, 0, 0, "rr5");

        // Backpressure: buffer holds data, no grants while out_rdy is low
        step(1, 0, 1, 0, 1, 0, 1, 0, "bp0");
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0, 1, "bp_hold");
        step(1, 0, 1, 0, 1, 1, 0, 1, "bp_release");
        step(0, 0, 0, 0, 1, 0, 0, 1, "bp_tail");
        step(0, 0, 0, 0, 1, 0, 0, 0, "bp_idle");

        // Domain switch 0 -> 1: drain, two gap cycles, then the locked data grant.
        // Inst (domain 0) arrives during the gap and must wait.
        step(1, 0, 0, 0, 1, 1, 0, 0, "sw_inst");
        step(0, 0, 1, 1, 1, 0, 0, 1, "sw_block");
        step(0, 0, 1, 1, 1, 0, 0, 0, "sw_drain");
        step(1, 0, 1, 1, 1, 0, 0, 0, "sw_gap1");
        step(1, 0, 1, 1, 1, 0, 0, 0, "sw_gap2");
        step(1, 0, 1, 1, 1, 0, 1, 0, "sw_grant");
        // Inst now needs its own switch back to domain 0
        step(1, 0, 0, 1, 1, 0, 0, 1, "sw2_block");
        step(1, 0, 0, 1, 1, 0, 0, 0, "sw2_drain");
        step(1, 0, 0, 1, 1, 0, 0, 0, "sw2_gap1");
        step(1, 0, 0, 1, 1, 0, 0, 0, "sw2_gap2");
        step(1, 0, 0, 1, 1, 1, 0, 0, "sw2_grant");
        step(0, 0, 0, 0, 1, 0, 0, 1, "sw2_tail");
        step(0, 0, 0, 0, 1, 0, 0, 0, "sw2_idle");

        // Asynchronous reset mid-cycle with a buffered request
        step(1, 0, 0, 0, 0, 1, 0, 0, "mr_fill");
        inst_val = 1'b1;
        data_val = 1'b1;
        out_rdy  = 1'b0;
        #2;
        chk("mr_oval_pre", MsgW'(o_val), MsgW'(1));
        reset = 1'b1;
        #1;
        chk("mr_oval", MsgW'(o_val),  '0);
        chk("mr_irdy", MsgW'(o_irdy), '0);
        chk("mr_drdy", MsgW'(o_drdy), '0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 0, 0, 0, 1, 1, 0, 0, "mr_lone0");
        step(0, 0, 0, 0, 1, 0, 0, 1, "mr_lone1");
        step(0, 0, 0, 0, 1, 0, 0, 0, "mr_lone2");

        // Gap disabled: mixed domains at full rate, alternating from data
        sel0 = 1'b1;
        step(1, 0, 1, 1, 1, 0, 1, 0, "g0_0");
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1, 0, 1, 1, 1, 1, 0, 1, "g0_inst");
            else            step(1, 0, 1, 1, 1, 0, 1, 1, "g0_data");
        end
        step(0, 0, 0, 0, 1, 0, 0, 1, "g0_tail");
        step(0, 0, 0, 0, 1, 0, 0, 0, "g0_idle");

        chk("sb_empty", MsgW'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plab5_mcore_mem_req_arbiter.md
# plab5_mcore_mem_req_arbiter

Arbitrates per-core instruction-cache and data-cache memory requests onto the single request path that feeds the memory-to-network request adapter. Registers the winning request in a one-entry output buffer and drives the adapter's `mode` (0 inst, 1 data) and `domain` inputs from that buffer. It uses round-robin fairness between the two requesters. When consecutive grants belong to different security domains, it drains the buffer and inserts a fixed idle gap, so domain switches have data-independent timing.

## Interface

- `p_mem_opaque_nbits`, 8: memory message opaque width (mo)
- `p_mem_addr_nbits`, 32: memory address width (ma)
- `p_mem_data_nbits`, 32: memory data width (md)
- `p_switch_gap`, 2: idle cycles inserted on a domain switch; 0 disables domain-switch handling
- `c_msg_nbits`, `VC_MEM_REQ_MSG_NBITS(mo,ma,md)`: derived, not set externally
- `clk` in 1: clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-high reset
- `inst_req_val` in 1: icache request valid
- `inst_req_rdy` out 1: icache request accepted this cycle
- `inst_req_msg` in c_msg_nbits: icache memory request message
- `inst_domain` in 1: security domain of the icache request
- `data_req_val` in 1: dcache request valid
- `data_req_rdy` out 1: dcache request accepted this cycle
- `data_req_msg` in c_msg_nbits: dcache memory request message
- `data_domain` in 1: security domain of the dcache request
- `out_val` out 1: buffered request valid toward the adapter
- `out_rdy` in 1: adapter/network accepts the buffered request
- `out_msg` out c_msg_nbits: buffered request message
- `out_mode` out 1: 0 = buffered request came from inst, 1 = from data
- `out_domain` out 1: domain of the buffered request

## Operation

- **Registered state**
  - `full`, buffer msg/mode/domain
  - `last`: last granted port, 0 inst / 1 data
  - `cur_dom`: domain of the last grant
  - `state`: one of RUN, DRAIN, GAP
  - `gap_cnt`: width `$clog2(p_switch_gap+1)`, minimum 1
  - `lock`: port held across a switch
- **Dequeue and space**
  - Dequeue: `deq = full && out_rdy`.
  - Space: `space = !full || out_rdy`.
- **Candidate selection**
  - If only one port is valid, the candidate is that port.
  - If both ports are valid, the candidate is the port that is not `last`.
  - If neither is valid, there is no candidate.
- **State RUN**
  - If a candidate exists and `space` holds:
    - If `p_switch_gap == 0` or the candidate's domain equals `cur_dom`, grant it.
    - Otherwise, grant nothing, set `lock` to the candidate, and go to DRAIN.
- **State DRAIN**
  - No grants.
  - When the buffer is empty, or `deq` occurs this cycle:
    - load `gap_cnt = p_switch_gap`;
    - set `cur_dom` to the locked port's domain;
    - go to GAP.
- **State GAP**
  - No grants; `gap_cnt` decrements each cycle.
  - In the cycle `gap_cnt == 1`, the transition back to RUN is registered. The next cycle, RUN grants `lock` unconditionally, bypassing round-robin.
  - The locked port remains valid, per the val/rdy hold rule for requesters.
- **Grant effects**
  - Assert the granted port's `_rdy` combinationally.
  - Load the buffer with that port's msg, mode (the port id) and domain; set `full`.
  - Update `last` to the granted port and `cur_dom` to its domain.
- **Buffer dequeue**
  - On `deq` without a simultaneous grant, clear `full`.
  - On `deq` with a simultaneous grant, the buffer is overwritten and stays full.
- **Rdy signals**
  - At most one `_rdy` is high per cycle.
  - `_rdy` never rises while its own `_val` is low.
- **Reset values**
  - `full = 0`, so `out_val = 0`.
  - `out_msg`, `out_mode`, `out_domain` = 0.
  - `last = 1`, so inst wins the first tie.
  - `cur_dom = 0`, `state = RUN`, `gap_cnt = 0`, `lock = 0`.
  - Both `_rdy` outputs are low during reset.
- **Reset mid-operation**
  - Any buffered request or pending switch is discarded.
  - Requesters must re-present their requests.

## Timing

- Latency is 1 cycle: a request accepted in cycle t appears on `out_val`/`out_msg` in cycle t+1.
- Throughput is 1 request/cycle for same-domain traffic when `out_rdy` stays high (pipelined dequeue and enqueue).
- `_rdy` depends combinationally on `_val`, `out_rdy`, `full` and state. No output depends on `out_rdy` except the `_rdy` signals.
- **Domain-switch cost**
  - The blocked candidate is first seen in cycle t (RUN → DRAIN).
  - The buffer drains in cycle d ≥ t+1, with DRAIN → GAP registered at d.
  - The switched request is granted in cycle d+1+p_switch_gap.
  - The switched request appears on `out_val` in cycle d+2+p_switch_gap.
- With `out_rdy` held low, the buffer holds its value indefinitely and no grants occur. This is backpressure.

## Test plan

- **Reset state:** assert `reset` asynchronously mid-cycle -> `out_val=0`, both `_rdy=0` immediately. After deassert, a lone `inst_req_val` is granted in the first cycle and shows `out_val=1`, `out_mode=0` next cycle.
- **Tie and round-robin:** both valid every cycle, same domain, `out_rdy=1` -> grants alternate inst, data, inst, data. Output shows `out_mode` 0,1,0,1 with no bubbles.
- **Backpressure:** buffer full, `out_rdy=0` for 5 cycles with both valid -> no `_rdy` asserted. `out_msg` stable. On `out_rdy=1`, the next grant happens in that same cycle.
- **Domain switch with `p_switch_gap=2`:**
  - Setup: inst domain 0 is buffered, then data domain 1 is requested, with `out_rdy=1`.
  - The data request is blocked until the buffer drains.
  - Exactly 2 idle cycles elapse, then data is granted.
  - `out_domain` changes 0 -> 1 with the computed cycle spacing.
- **Switch lock:** during GAP, a same-domain-0 inst request arrives -> it is not granted. The locked data request is granted first, and inst follows only after a further switch sequence.
- **Gap disabled:** `p_switch_gap=0` with mixed domains alternating -> full 1/cycle throughput, and DRAIN/GAP are never entered.
